hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and sequencing controller for the RV32I 5-stage core. It produces the hold (stall) and bubble (flush) controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, covering three cases: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses. A small FSM tracks outstanding memory accesses with a timeout watchdog. Saturating counters record stall and flush cycles for performance analysis.

## Interface
- `TIMEOUT_CYC`, 64: maximum cycles spent in MEM_WAIT before the watchdog fires (≥2).
- `CNT_W`, 32: width of the performance counters.

- `clk`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Synchronous, active-high.
- `id_Rs1`, `id_Rs2`  in  5 each  Source register indices of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  The ID instruction actually reads that source.
- `ex_rd`  in  5  Destination register of the instruction in EX.
- `ex_mem_read`  in  1  The EX instruction is a load.
- `ex_branch_taken`  in  1  A branch or jump in EX redirects the PC this cycle.
- `mem_req`  in  1  The MEM stage issues or holds a data-memory access.
- `mem_ready`  in  1  The data memory completes the access this cycle.
- `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall`, `mem_wb_stall`  out  1 each  Hold the register.
- `if_id_flush`, `id_ex_flush`  out  1 each  Clear the register to a bubble. Flush has priority over stall inside the pipeline registers.
- `mem_timeout`  out  1  Sticky watchdog error flag.
- `stall_cnt`  out  `CNT_W`  Cycles with `pc_stall`=1.
- `flush_cnt`  out  `CNT_W`  Cycles with `id_ex_flush`=1.

## Operation
- **FSM states:** RUN, MEM_WAIT.
  - RUN → MEM_WAIT when `mem_req` && !`mem_ready`.
  - MEM_WAIT → RUN when `mem_ready`, or when the wait counter reaches `TIMEOUT_CYC`-1. On a timeout exit, `mem_timeout` is set.
  - Reset → RUN.
- **Memory wait** (`memw`):
  - `memw` = (RUN && `mem_req` && !`mem_ready`) || (MEM_WAIT && !`mem_ready` && !timeout_exit).
  - While `memw`=1, all five stall outputs are 1 and both flush outputs are 0.
  - A pending branch or load-use condition is suppressed and re-evaluated after release. This prevents killing the branch held in ID/EX while EX/MEM is frozen.
- **Taken branch** (`!memw` && `ex_branch_taken`):
  - `if_id_flush`=1 and `id_ex_flush`=1.
  - All stalls are 0.
- **Load-use** (`!memw` && !`ex_branch_taken` && `ex_mem_read` && `ex_rd`≠0 && ((`id_use_rs1` && `id_Rs1`==`ex_rd`) || (`id_use_rs2` && `id_Rs2`==`ex_rd`))):
  - `pc_stall`=1, `if_id_stall`=1, `id_ex_flush`=1.
  - The remaining outputs are 0.
- **Priority:** `memw` > branch > load-use. A branch coinciding with a load-use hazard flushes; it does not stall, because the dependent ID instruction is squashed anyway.
- `id_ex_stall`, `ex_mem_stall` and `mem_wb_stall` are 1 only under `memw`.
- **Wait counter:**
  - Cleared on entry to MEM_WAIT.
  - Increments each MEM_WAIT cycle.
  - Width is ceil(log2(`TIMEOUT_CYC`)).
- **Performance counters:**
  - `stall_cnt` increments each cycle `pc_stall`=1; `flush_cnt` increments each cycle `id_ex_flush`=1.
  - Both saturate at 2^`CNT_W`-1 and do not wrap.
- **`mem_timeout`:** stays 1 until `reset`. Operation continues after a timeout.

## Timing
- All stall and flush outputs are combinational from the inputs and the FSM state. They act at the same rising edge and have zero cycles of latency.
- Counters, FSM state and `mem_timeout` update at the rising edge and are visible one cycle later.
- A load-use hazard produces exactly one bubble: on the next cycle the load has moved to MEM and the hazard term drops.
- A zero-wait access (`mem_req` && `mem_ready` in the same RUN cycle) causes no stall and no state change.
- A k-cycle access (`mem_ready` on the k-th cycle of `mem_req`) produces k-1 stall cycles.
- **While `reset`=1:**
  - All stall and flush outputs are forced to 0.
  - The FSM goes to RUN.
  - Wait counter, `stall_cnt`, `flush_cnt` and `mem_timeout` are cleared to 0.
- Reset asserted during MEM_WAIT returns the FSM to RUN on that edge with no timeout flag.
- Output reset values: all outputs 0.

## Test plan
- **Load-use:**
  - Stimulus: `ex_mem_read`=1, `ex_rd`=5, `id_Rs1`=5, `id_use_rs1`=1 for 1 cycle.
  - Required: `pc_stall`=`if_id_stall`=`id_ex_flush`=1, others 0; `stall_cnt`=1 and `flush_cnt`=1 next cycle.
- **Load to x0:**
  - Stimulus: `ex_rd`=0 with a matching `id_Rs1`=0.
  - Required: all outputs 0.
- **Branch with load-use:**
  - Stimulus: `ex_branch_taken`=1 together with the load-use inputs.
  - Required: `if_id_flush`=`id_ex_flush`=1, `pc_stall`=0.
- **Multi-cycle access with branch:**
  - Stimulus: `mem_req` held 4 cycles, `mem_ready` on the 4th, `ex_branch_taken`=1 throughout.
  - Required: all stalls 1 and flushes 0 for cycles 1-3; cycle 4 gives the flushes only; `stall_cnt`=3.
- **Watchdog:**
  - Stimulus: `TIMEOUT_CYC`=4, `mem_req`=1, `mem_ready`=0 forever.
  - Required: stalls for exactly 4 cycles, then `mem_timeout`=1 (sticky). The FSM re-enters MEM_WAIT on the following request cycle.
- **Reset mid-wait and saturation:**
  - Stimulus: `reset` in the 2nd MEM_WAIT cycle; separately, `CNT_W`=3 with 10 stall cycles.
  - Required: reset gives outputs 0, state RUN and counters 0; the saturation case holds `stall_cnt` at 7.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and sequencing controller for the RV32I 5-stage pipeline. It generates
// hold (stall) and bubble (flush) controls for the PC and the four pipeline
// registers. Three situations are handled: load-use hazards, taken branches
// resolved in EX, and multi-cycle data-memory accesses. A two-state FSM tracks
// an outstanding memory access and runs a timeout watchdog. Two saturating
// counters record stall and flush cycles.
//
// Parameters
//   TIMEOUT_CYC  maximum cycles spent in MEM_WAIT before the watchdog fires (>=2)
//   CNT_W        width of the performance counters
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   id_Rs1, id_Rs2                  source registers of the ID instruction
//   id_use_rs1, id_use_rs2          the ID instruction really reads that source
//   ex_rd, ex_mem_read              destination / is-load of the EX instruction
//   ex_branch_taken                 EX redirects the PC this cycle
//   mem_req, mem_ready              data-memory access handshake (see below)
//   pc_stall .. mem_wb_stall        hold the corresponding register
//   if_id_flush, id_ex_flush        turn the register into a bubble
//   mem_timeout                     sticky watchdog error flag
//   stall_cnt, flush_cnt            saturating performance counters
//   state_dbg                       current FSM state (0 = RUN, 1 = MEM_WAIT)
//
// Memory handshake: mem_req is high for every cycle the MEM stage has an
// access in flight; the access completes in the cycle where mem_ready is high.
// mem_req && mem_ready in the same RUN cycle is a zero-wait access. Once in
// MEM_WAIT, only mem_ready (or the watchdog) ends the wait.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_Rs1,
    input  logic [4:0]       id_Rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             mem_wb_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             state_dbg
);

    localparam int WC_W = ($clog2(TIMEOUT_CYC) < 1) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT_CYC - 1);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    logic [0:0]      state;
    logic [WC_W-1:0] wait_cnt;

    logic in_run;
    logic in_wait;
    logic timeout_exit;
    logic memw;
    logic rs_match;
    logic load_use;

    always_comb begin
        in_run       = (state == ST_RUN);
        in_wait      = (state == ST_MEM_WAIT);
        // The watchdog fires only if the access has still not completed in
        // the last allowed wait cycle; that cycle is released, not stalled.
        timeout_exit = in_wait && !mem_ready && (wait_cnt == WAIT_LAST);
        memw         = (in_run && mem_req && !mem_ready)
                     || (in_wait && !mem_ready && !timeout_exit);
        rs_match     = (id_use_rs1 && (id_Rs1 == ex_rd))
                     || (id_use_rs2 && (id_Rs2 == ex_rd));
        // x0 is never really written, so a load to x0 cannot create a hazard.
        load_use     = ex_mem_read && (ex_rd != 5'd0) && rs_match;
    end

    // Priority: memory wait > taken branch > load-use. During a memory wait
    // nothing is flushed, because ID/EX may hold a branch that must survive
    // until EX/MEM unfreezes; the branch is re-evaluated after release.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        if (!reset) begin
            if (memw) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_stall = 1'b1;
            end else if (ex_branch_taken) begin
                // The dependent ID instruction is squashed anyway, so a
                // coincident load-use hazard needs no stall.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_req && !mem_ready) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        state <= ST_RUN;
                    end else if (timeout_exit) begin
                        state       <= ST_RUN;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (id_ex_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign state_dbg = state[0];

endmodule
